// File: rtl/time_entry.sv
// Keypad-side time entry for the microwave countdown chain: collects an MM:SS
// buffer, validates it on start, pulses the timer parallel load and tracks the run.
module time_entry #(
   parameter int SEC_TENS_MAX = 5,
   parameter int MAX_DIGITS   = 4
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       start,
   input  logic       cancel,
   input  logic       timer_done,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       loadn,
   output logic       abort,
   output logic       running,
   output logic [2:0] digit_count,
   output logic       entry_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t     state, state_nxt;

   logic       do_shift, do_clear;
   logic [3:0] min_tens_nxt, min_ones_nxt, sec_tens_nxt, sec_ones_nxt;
   logic [2:0] count_nxt;
   logic       loadn_nxt, abort_nxt, running_nxt, err_nxt;

   logic       is_digit, buf_zero, buf_bad, buf_full;

   assign is_digit = (key_code <= 4'd9);
   assign buf_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'd0);
   assign buf_bad  = (sec_tens > 4'(SEC_TENS_MAX));
   assign buf_full = (digit_count >= 3'(MAX_DIGITS));

   // Control decisions. Within a cycle cancel masks start, start masks a key.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_nxt = state;
      do_shift  = 1'b0;
      do_clear  = 1'b0;
      loadn_nxt = 1'b1;
      abort_nxt = 1'b0;
      err_nxt   = 1'b0;

      unique case (state)
         IDLE: begin
            if (!cancel) begin
               if (start) begin
                  err_nxt = 1'b1;
               end else if (key_valid) begin
                  if (is_digit) begin
                     do_shift  = 1'b1;
                     state_nxt = ENTRY;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
         end

         ENTRY: begin
            if (cancel) begin
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end else if (start) begin
               if (buf_zero || buf_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  loadn_nxt = 1'b0;
                  state_nxt = LOAD;
               end
            end else if (key_valid) begin
               if (!is_digit || buf_full) err_nxt  = 1'b1;
               else                       do_shift = 1'b1;
            end
         end

         // The load pulse is already on the wire; a cancel here aborts right after it.
         LOAD: begin
            if (cancel) begin
               abort_nxt = 1'b1;
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = RUN;
            end
         end

         RUN: begin
            if (cancel) begin
               abort_nxt = 1'b1;
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end else if (timer_done) begin
               do_clear  = 1'b1;
               state_nxt = IDLE;
            end
         end

         default: begin
            do_clear  = 1'b1;
            state_nxt = IDLE;
         end
      endcase

      running_nxt = (state_nxt == RUN);
   end

   // Buffer datapath: digits enter at the right and walk toward min_tens.
   always_comb begin
      min_tens_nxt = min_tens;
      min_ones_nxt = min_ones;
      sec_tens_nxt = sec_tens;
      sec_ones_nxt = sec_ones;
      count_nxt    = digit_count;
      if (do_clear) begin
         min_tens_nxt = 4'd0;
         min_ones_nxt = 4'd0;
         sec_tens_nxt = 4'd0;
         sec_ones_nxt = 4'd0;
         count_nxt    = 3'd0;
      end else if (do_shift) begin
         min_tens_nxt = min_ones;
         min_ones_nxt = sec_tens;
         sec_tens_nxt = sec_ones;
         sec_ones_nxt = key_code;
         count_nxt    = digit_count + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state       <= IDLE;
         min_tens    <= 4'd0;
         min_ones    <= 4'd0;
         sec_tens    <= 4'd0;
         sec_ones    <= 4'd0;
         digit_count <= 3'd0;
         loadn       <= 1'b1;
         abort       <= 1'b0;
         running     <= 1'b0;
         entry_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
         state       <= state_nxt;
         min_tens    <= min_tens_nxt;
         min_ones    <= min_ones_nxt;
         sec_tens    <= sec_tens_nxt;
         sec_ones    <= sec_ones_nxt;
         digit_count <= count_nxt;
         loadn       <= loadn_nxt;
         abort       <= abort_nxt;
         running     <= running_nxt;
         entry_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed scenarios plus random keypad
// traffic against a digit-queue reference model.
module tb_time_entry;

   localparam int SEC_TENS_MAX = 5;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       timer_done = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       loadn, abort, running, entry_err;
   logic [2:0] digit_count;

   time_entry #(.SEC_TENS_MAX(SEC_TENS_MAX), .MAX_DIGITS(4)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .start       (start),
      .cancel      (cancel),
      .timer_done  (timer_done),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .loadn       (loadn),
      .abort       (abort),
      .running     (running),
      .digit_count (digit_count),
      .entry_err   (entry_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the entered digits as a queue, mode as a small integer.
   localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3;
   int m_mode = M_IDLE;
   int q[$];
   bit e_loadn = 1'b1, e_abort = 1'b0, e_err = 1'b0;

   function automatic int buf_digit(int pos);
      if (q.size() > pos) return q[q.size() - 1 - pos];
      return 0;
   endfunction

   function automatic int buf_value();
      int v = 0;
      foreach (q[i]) v = v * 10 + q[i];
      return v;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      q.delete();
      e_loadn = 1'b1;
      e_abort = 1'b0;
      e_err   = 1'b0;
   endtask

   task automatic model_step(input bit c, input bit s, input bit kv, input int kc, input bit d);
      int v;
      e_loadn = 1'b1;
      e_abort = 1'b0;
      e_err   = 1'b0;
      case (m_mode)
         M_IDLE: begin
            if (c) begin
            end else if (s) begin
               e_err = 1'b1;
            end else if (kv) begin
               if (kc <= 9) begin
                  q.push_back(kc);
                  m_mode = M_ENTRY;
               end else e_err = 1'b1;
            end
         end
         M_ENTRY: begin
            if (c) begin
               q.delete();
               m_mode = M_IDLE;
            end else if (s) begin
               v = buf_value();
               if (v == 0 || (v % 100) / 10 > SEC_TENS_MAX) e_err = 1'b1;
               else begin
                  e_loadn = 1'b0;
                  m_mode  = M_LOAD;
               end
            end else if (kv) begin
               if (kc > 9 || q.size() == 4) e_err = 1'b1;
               else q.push_back(kc);
            end
         end
         M_LOAD: begin
            if (c) begin
               e_abort = 1'b1;
               q.delete();
               m_mode = M_IDLE;
            end else m_mode = M_RUN;
         end
         default: begin
            if (c) begin
               e_abort = 1'b1;
               q.delete();
               m_mode = M_IDLE;
            end else if (d) begin
               q.delete();
               m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   task automatic compare_all(input string ctx);
      check({ctx, " min_tens"}, 32'(min_tens), 32'(buf_digit(3)));
      check({ctx, " min_ones"}, 32'(min_ones), 32'(buf_digit(2)));
      check({ctx, " sec_tens"}, 32'(sec_tens), 32'(buf_digit(1)));
      check({ctx, " sec_ones"}, 32'(sec_ones), 32'(buf_digit(0)));
      check({ctx, " digit_count"}, 32'(digit_count), 32'(q.size()));
      check({ctx, " loadn"}, 32'(loadn), 32'(e_loadn));
      check({ctx, " abort"}, 32'(abort), 32'(e_abort));
      check({ctx, " running"}, 32'(running), 32'(m_mode == M_RUN));
      check({ctx, " entry_err"}, 32'(entry_err), 32'(e_err));
   endtask

   task automatic step(input string ctx, input bit c, input bit s, input bit kv,
                       input logic [3:0] kc, input bit d);
      @(negedge clk);
      cancel     = c;
      start      = s;
      key_valid  = kv;
      key_code   = kc;
      timer_done = d;
      @(posedge clk);
      model_step(c, s, kv, int'(kc), d);
      #1;
      compare_all(ctx);
   endtask

   task automatic key(input string ctx, input logic [3:0] k);
      step(ctx, 1'b0, 1'b0, 1'b1, k, 1'b0);
   endtask

   task automatic idle(input string ctx);
      step(ctx, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic press_start(input string ctx);
      step(ctx, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic press_cancel(input string ctx);
      step(ctx, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   // Reset asserted mid-cycle, away from any clock edge.
   task automatic async_reset(input string ctx);
      @(negedge clk);
      cancel = 1'b0; start = 1'b0; key_valid = 1'b0; timer_done = 1'b0;
      #2 clrn = 1'b0;
      model_reset();
      #1 compare_all({ctx, " async"});
      @(posedge clk);
      #1 compare_all({ctx, " held"});
      @(negedge clk);
      clrn = 1'b1;
   endtask

   initial begin
      bit c, s, kv, d;
      logic [3:0] kc;

      model_reset();
      #12 compare_all("reset");
      @(negedge clk);
      clrn = 1'b1;

      // 1: 01:30 load and run
      key("t1 k1", 4'd1);
      key("t1 k3", 4'd3);
      key("t1 k0", 4'd0);
      press_start("t1 start");
      idle("t1 run");
      idle("t1 run2");
      press_cancel("t1 cancel");

      // 2: overflowing keys and an invalid seconds-tens start
      key("t2 k9a", 4'd9);
      key("t2 k9b", 4'd9);
      key("t2 k9c", 4'd9);
      key("t2 k9d", 4'd9);
      key("t2 k5", 4'd5);
      press_start("t2 start");
      idle("t2 hold");
      press_cancel("t2 cancel");

      // 3: all-zero start, non-digit in IDLE, start in IDLE
      key("t3 k0", 4'd0);
      press_start("t3 start");
      press_cancel("t3 cancel");
      key("t3 k10", 4'd10);
      press_start("t3 idle start");
      key("t3 k15 idle", 4'd15);

      // 4: 00:45 run ended by timer_done, concurrent start ignored
      key("t4 k4", 4'd4);
      key("t4 k5", 4'd5);
      key("t4 k12", 4'd12);
      press_start("t4 start");
      idle("t4 load");
      step("t4 run key", 1'b0, 1'b1, 1'b1, 4'd3, 1'b0);
      step("t4 done", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
      idle("t4 after");

      // 5: cancel beats timer_done; start beats a key
      key("t5 k1", 4'd1);
      key("t5 k2", 4'd2);
      press_start("t5 start");
      idle("t5 load");
      step("t5 cancel+done", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      idle("t5 after abort");
      key("t5 k3", 4'd3);
      step("t5 k7+start", 1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
      idle("t5 run");
      press_cancel("t5 cancel");

      // cancel during the load cycle: load completes, then abort
      key("tl k2", 4'd2);
      press_start("tl start");
      press_cancel("tl cancel in load");
      idle("tl after");

      // 6: asynchronous reset mid-RUN and during the load pulse
      key("t6 k5", 4'd5);
      press_start("t6 start");
      idle("t6 run");
      async_reset("t6 run");
      key("t6 k5b", 4'd5);
      press_start("t6 start2");
      async_reset("t6 load");
      idle("t6 after");

      // Random traffic, with occasional resets
      for (int i = 0; i < 1500; i++) begin
         c  = ($urandom_range(0, 99) < 4);
         s  = ($urandom_range(0, 9) == 0);
         kv = ($urandom_range(0, 9) < 4);
         kc = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
         d  = ($urandom_range(0, 19) == 0);
         step("rand", c, s, kv, kc, d);
         if ($urandom_range(0, 299) == 0) async_reset("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
